// File: rtl/key_cond_pkg.sv
// Shared types and default timing for the pushbutton conditioner.
// Defaults assume a 50 MHz system clock.
package key_cond_pkg;

  typedef enum logic [1:0] {
    S_UP  = 2'd0,
    S_DLY = 2'd1,
    S_RPT = 2'd2
  } rpt_state_e;

  localparam int unsigned DEBOUNCE_CYC_DEF = 1_000_000;  // 20 ms
  localparam int unsigned REPEAT_DLY_DEF   = 25_000_000; // 500 ms
  localparam int unsigned REPEAT_PER_DEF   = 5_000_000;  // 100 ms

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_cond_chan.sv
// Single key channel: two-flop synchronizer, debounce counter, press/release
// edge pulses and an optional auto-repeat FSM.
module key_cond_chan
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned REPEAT_DLY   = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_PER   = REPEAT_PER_DEF,
  parameter bit          REPEAT_EN    = 1'b0
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_rpt
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC);
  localparam int unsigned RPT_MAX = max_u(REPEAT_DLY, REPEAT_PER);
  localparam int unsigned RC_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  logic            sync1_q, sync2_q;
  logic            sync_pressed;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            press_q, release_q;
  logic            rpt_q, rpt_d;
  rpt_state_e      state_q, state_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;

  assign sync_pressed = ~sync2_q;

  // A new level must be seen DEBOUNCE_CYC consecutive cycles; any match restarts.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync_pressed != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Down-counter shared by the initial delay and the repeat period.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    if (!REPEAT_EN) begin
      state_d = S_UP;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_UP: begin
          if (level_d) begin
            state_d = S_DLY;
            rcnt_d  = RC_W'(REPEAT_DLY - 1);
          end
        end
        S_DLY, S_RPT: begin
          if (!level_d) begin
            state_d = S_UP;
            rcnt_d  = '0;
          end else if (rcnt_q == '0) begin
            rpt_d   = 1'b1;
            state_d = S_RPT;
            rcnt_d  = RC_W'(REPEAT_PER - 1);
          end else begin
            rcnt_d = rcnt_q - RC_W'(1);
          end
        end
        default: begin
          state_d = S_UP;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
      state_q   <= S_UP;
      rcnt_q    <= '0;
    end else begin
      sync1_q   <= i_key;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= level_d & ~level_q;
      release_q <= ~level_d & level_q;
      rpt_q     <= rpt_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_rpt     = rpt_q;

endmodule

// File: rtl/key_cond.sv
// Pushbutton conditioner: NUM_KEYS independent debounced channels with
// press/release pulses and per-key auto-repeat.
module key_cond
  import key_cond_pkg::*;
#(
  parameter int unsigned          NUM_KEYS     = 4,
  parameter int unsigned          DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
  parameter int unsigned          REPEAT_DLY   = REPEAT_DLY_DEF,
  parameter int unsigned          REPEAT_PER   = REPEAT_PER_DEF,
  parameter logic [NUM_KEYS-1:0]  REPEAT_MASK  = NUM_KEYS'(4'b0100)
) (
  input  logic                i_clk,
  input  logic                i_srst,
  input  logic [NUM_KEYS-1:0] i_key,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_release,
  output logic [NUM_KEYS-1:0] o_rpt
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_cond_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DLY   (REPEAT_DLY),
      .REPEAT_PER   (REPEAT_PER),
      .REPEAT_EN    (REPEAT_MASK[g])
    ) u_chan (
      .i_clk     (i_clk),
      .i_srst    (i_srst),
      .i_key     (i_key[g]),
      .o_level   (o_level[g]),
      .o_press   (o_press[g]),
      .o_release (o_release[g]),
      .o_rpt     (o_rpt[g])
    );
  end

endmodule

// File: tb/tb_key_cond.sv
// Self-checking bench for key_cond: directed scenarios against fixed timing
// plus randomized key activity against a window-based reference model.
module tb_key_cond;

  localparam int unsigned DB    = 8;
  localparam int unsigned DLY   = 20;
  localparam int unsigned PER   = 5;
  localparam logic [3:0]  MASK  = 4'b0100;
  localparam int          MAXC  = 4096;

  logic       clk = 1'b0;
  logic       i_srst;
  logic [3:0] i_key;
  logic [3:0] o_level, o_press, o_release, o_rpt;

  int checks = 0;
  int errors = 0;
  int cyc;

  // Reference model history, indexed by clock edge number.
  logic [3:0] s1m   [MAXC];
  logic [3:0] syncm [MAXC];
  logic [3:0] lvlm  [MAXC];
  logic [3:0] prsm  [MAXC];
  logic [3:0] relm  [MAXC];
  logic [3:0] rptm  [MAXC];
  int         lastp [4];

  always #5 clk = ~clk;

  key_cond #(
    .NUM_KEYS     (4),
    .DEBOUNCE_CYC (DB),
    .REPEAT_DLY   (DLY),
    .REPEAT_PER   (PER),
    .REPEAT_MASK  (MASK)
  ) dut (
    .i_clk     (clk),
    .i_srst    (i_srst),
    .i_key     (i_key),
    .o_level   (o_level),
    .o_press   (o_press),
    .o_release (o_release),
    .o_rpt     (o_rpt)
  );

  // Drive one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic tick(input logic [3:0] key, input logic srst);
    logic flip;
    int   t;
    i_key  = key;
    i_srst = srst;
    @(posedge clk);
    cyc++;
    t = cyc;
    if (t >= MAXC) begin
      $display("FAIL cycle_budget got %0d required below %0d", t, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    for (int k = 0; k < 4; k++) begin
      if (srst) begin
        s1m[t][k]   = 1'b1;
        syncm[t][k] = 1'b0;
        lvlm[t][k]  = 1'b0;
        prsm[t][k]  = 1'b0;
        relm[t][k]  = 1'b0;
        rptm[t][k]  = 1'b0;
      end else begin
        s1m[t][k]   = key[k];
        syncm[t][k] = ~s1m[t-1][k];
        // Level flips once the synchronized key has disagreed with a steady level
        // for the whole of the last DB cycles.
        flip = 1'b1;
        for (int c = t - int'(DB); c <= t - 1; c++) begin
          if (syncm[c][k] == lvlm[t-1][k] || lvlm[c][k] != lvlm[t-1][k]) flip = 1'b0;
        end
        lvlm[t][k] = flip ? ~lvlm[t-1][k] : lvlm[t-1][k];
        prsm[t][k] = lvlm[t][k] & ~lvlm[t-1][k];
        relm[t][k] = ~lvlm[t][k] & lvlm[t-1][k];
        if (prsm[t][k]) lastp[k] = t;
        rptm[t][k] = MASK[k] && lvlm[t][k] && !prsm[t][k] && (t - lastp[k] >= int'(DLY))
                     && (((t - lastp[k] - int'(DLY)) % int'(PER)) == 0);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'b1111, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(4'($urandom_range(0, 15)), 1'b1);
      checks++;
      if ({o_level, o_press, o_release, o_rpt} !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs got %h required 0000",
                 {o_level, o_press, o_release, o_rpt});
      end
    end
    idle(12);
    checks++;
    if ({o_level, o_press, o_release, o_rpt} !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle got %h required 0000", {o_level, o_press, o_release, o_rpt});
    end
  endtask

  task automatic test_clean_press();
    int np = 0, pc = -1, rc = -1, nr = 0;
    logic bad_lvl = 1'b0, bad_rpt = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick((i <= 30) ? 4'b1110 : 4'b1111, 1'b0);
      if (o_press[0]) begin np++; pc = i; end
      if (o_release[0]) begin nr++; rc = i; end
      if (o_rpt[0]) bad_rpt = 1'b1;
      if (o_level[0] !== (i >= 10 && i < 40)) bad_lvl = 1'b1;
    end
    checks++;
    if (np != 1 || pc != 10) begin
      errors++;
      $display("FAIL clean_press count=%0d cycle=%0d required count=1 cycle=10", np, pc);
    end
    checks++;
    if (bad_lvl) begin
      errors++;
      $display("FAIL clean_level got wrong o_level[0] required 1 for cycles 10..39 only");
    end
    checks++;
    if (bad_rpt) begin
      errors++;
      $display("FAIL clean_no_rpt got o_rpt[0]=1 required 0");
    end
    checks++;
    if (nr != 1 || rc != 40) begin
      errors++;
      $display("FAIL clean_release count=%0d cycle=%0d required count=1 cycle=40", nr, rc);
    end
    idle(4);
  endtask

  task automatic test_bounce();
    int np = 0, pc = -1, ev = 0;
    logic [3:0] k;
    for (int i = 1; i <= 50; i++) begin
      k = 4'b1111;
      if (i > 30 || (((i - 1) / 3) % 2) == 0) k[1] = 1'b0;
      tick(k, 1'b0);
      if (i <= 30 && (o_press[1] || o_release[1] || o_level[1])) ev++;
      if (o_press[1]) begin np++; pc = i; end
    end
    checks++;
    if (ev != 0) begin
      errors++;
      $display("FAIL bounce_quiet got %0d event cycles required 0", ev);
    end
    checks++;
    if (np != 1 || pc != 40) begin
      errors++;
      $display("FAIL bounce_press count=%0d cycle=%0d required count=1 cycle=40", np, pc);
    end
    idle(14);
  endtask

  task automatic test_auto_repeat();
    int pc = -1, nr = 0, rc = -1, bad = 0, both = 0;
    logic exp_rpt;
    for (int i = 1; i <= 100; i++) begin
      tick((i <= 65) ? 4'b1011 : 4'b1111, 1'b0);
      // Release lands on what would have been a repeat slot (cycle 75).
      exp_rpt = (i >= 10 + int'(DLY)) && (i < 75) && (((i - 10 - int'(DLY)) % int'(PER)) == 0);
      if (o_press[2] && pc < 0) pc = i;
      if (o_release[2]) begin nr++; rc = i; end
      if (o_rpt[2] !== exp_rpt) bad++;
      if (o_press[2] && o_rpt[2]) both++;
    end
    checks++;
    if (pc != 10) begin
      errors++;
      $display("FAIL rpt_press got cycle %0d required 10", pc);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rpt_pulses got %0d wrong cycles required 0 (pulses at 30,35..70)", bad);
    end
    checks++;
    if (nr != 1 || rc != 75) begin
      errors++;
      $display("FAIL rpt_release count=%0d cycle=%0d required count=1 cycle=75", nr, rc);
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL rpt_overlap got %0d press+rpt cycles required 0", both);
    end
    idle(4);
  endtask

  task automatic test_reset_mid_hold();
    int pc = -1, bad = 0, rc = -1, zbad = 0;
    logic exp_rpt;
    for (int i = 1; i <= 100; i++) begin
      tick((i <= 75) ? 4'b1011 : 4'b1111, (i >= 36 && i <= 38));
      if (i >= 36 && i <= 38) begin
        if ({o_level, o_press, o_release, o_rpt} !== 16'h0) zbad++;
      end else if (i > 38) begin
        exp_rpt = (i >= 48 + int'(DLY)) && (i < 85) && (((i - 48 - int'(DLY)) % int'(PER)) == 0);
        if (o_press[2] && pc < 0) pc = i;
        if (o_release[2] && rc < 0) rc = i;
        if (o_rpt[2] !== exp_rpt) bad++;
      end
    end
    checks++;
    if (zbad != 0) begin
      errors++;
      $display("FAIL midrst_zero got %0d nonzero cycles required 0", zbad);
    end
    checks++;
    if (pc != 48) begin
      errors++;
      $display("FAIL midrst_press got cycle %0d required 48", pc);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_rpt got %0d wrong cycles required 0 (pulses at 68,73,78,83)", bad);
    end
    checks++;
    if (rc != 85) begin
      errors++;
      $display("FAIL midrst_release got cycle %0d required 85", rc);
    end
    idle(4);
  endtask

  task automatic test_simultaneous();
    int np = 0, pc = -1, rc = -1, nrpt = 0;
    logic [3:0] pv = 4'b0, rv = 4'b0;
    for (int i = 1; i <= 55; i++) begin
      tick((i <= 40) ? 4'b0110 : 4'b1111, 1'b0);
      if (o_press != 4'b0) begin np++; pc = i; pv = o_press; end
      if (o_release != 4'b0 && rc < 0) begin rc = i; rv = o_release; end
      if (o_rpt[0] || o_rpt[3]) nrpt++;
    end
    checks++;
    if (np != 1 || pc != 10 || pv !== 4'b1001) begin
      errors++;
      $display("FAIL simul_press count=%0d cycle=%0d value=%b required 1 cycle 10 1001",
               np, pc, pv);
    end
    checks++;
    if (rc != 50 || rv !== 4'b1001) begin
      errors++;
      $display("FAIL simul_release cycle=%0d value=%b required cycle 50 1001", rc, rv);
    end
    checks++;
    if (nrpt != 0) begin
      errors++;
      $display("FAIL simul_no_rpt got %0d cycles required 0", nrpt);
    end
  endtask

  task automatic test_glitch();
    int np = 0, nl = 0, pc = -1, rc = -1;
    for (int i = 1; i <= 25; i++) begin
      tick((i <= 7) ? 4'b0111 : 4'b1111, 1'b0);
      if (o_press[3]) np++;
      if (o_level[3]) nl++;
    end
    checks++;
    if (np != 0 || nl != 0) begin
      errors++;
      $display("FAIL glitch7 got press=%0d level_cycles=%0d required 0 0", np, nl);
    end
    // Exactly DEBOUNCE_CYC stable cycles is the shortest accepted press.
    for (int i = 1; i <= 25; i++) begin
      tick((i <= 8) ? 4'b0111 : 4'b1111, 1'b0);
      if (o_press[3] && pc < 0) pc = i;
      if (o_release[3] && rc < 0) rc = i;
    end
    checks++;
    if (pc != 10 || rc != 18) begin
      errors++;
      $display("FAIL glitch8 got press=%0d release=%0d required 10 18", pc, rc);
    end
  endtask

  task automatic test_random();
    int dur [4];
    int rst_left = 0;
    logic [3:0] kv = 4'b1111;
    for (int k = 0; k < 4; k++) dur[k] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (dur[k] == 0) begin
          kv[k]  = 1'($urandom_range(0, 1));
          dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 70))
                                               : int'($urandom_range(1, 12));
        end
        dur[k]--;
      end
      if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = 3;
      tick(kv, rst_left != 0);
      if (rst_left > 0) rst_left--;
      checks++;
      if ({o_level, o_press, o_release, o_rpt} !==
          {lvlm[cyc], prsm[cyc], relm[cyc], rptm[cyc]}) begin
        errors++;
        $display("FAIL random cyc=%0d got lvl=%b prs=%b rel=%b rpt=%b required %b %b %b %b",
                 cyc, o_level, o_press, o_release, o_rpt,
                 lvlm[cyc], prsm[cyc], relm[cyc], rptm[cyc]);
      end
      checks++;
      if ((o_press & o_rpt) !== 4'b0) begin
        errors++;
        $display("FAIL random_overlap cyc=%0d got %b required 0000", cyc, o_press & o_rpt);
      end
    end
  endtask

  initial begin
    i_key  = 4'b1111;
    i_srst = 1'b1;
    for (int c = 0; c < MAXC; c++) begin
      s1m[c]   = 4'b1111;
      syncm[c] = 4'b0;
      lvlm[c]  = 4'b0;
      prsm[c]  = 4'b0;
      relm[c]  = 4'b0;
      rptm[c]  = 4'b0;
    end
    for (int k = 0; k < 4; k++) lastp[k] = -1000;
    cyc = 16;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_reset_mid_hold();
    test_simultaneous();
    test_glitch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_cond.md
# key_cond

Pushbutton input conditioner for the clock design. It turns raw, bouncing, active-low board keys into clean single-cycle press, release and auto-repeat events in the system clock domain, plus a debounced level per key. It sits between the board keys and the mode, set and increment logic. Downstream logic samples these outputs synchronously and never uses a key as a clock.

## Interface
Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYC, 1_000_000, cycles a new raw level must be stable before it is accepted (20 ms at 50 MHz); must be ≥ 2.
- REPEAT_DLY, 25_000_000, cycles from o_press to the first o_rpt while held; must be ≥ 1.
- REPEAT_PER, 5_000_000, cycles between successive o_rpt while held; must be ≥ 1.
- REPEAT_MASK, 4'b0100, per-key auto-repeat enable (default: only key 2, the time-increment key).

Ports:
- i_clk, in, 1, system clock. Single clock domain.
- i_srst, in, 1, synchronous active-high reset.
- i_key, in, NUM_KEYS, raw keys: asynchronous, active-low, 0 = pressed.
- o_level, out, NUM_KEYS, debounced state: 1 = pressed.
- o_press, out, NUM_KEYS, 1-cycle pulse on an accepted press.
- o_release, out, NUM_KEYS, 1-cycle pulse on an accepted release.
- o_rpt, out, NUM_KEYS, 1-cycle auto-repeat pulse.

## Operation
Each channel is independent and identical.

- **Synchronizer.** Two flops per key. Reset value is 1 (released). Inverted output gives the active-high `sync_pressed`.
- **Debounce counter.** Width `$clog2(DEBOUNCE_CYC)`.
  - If `sync_pressed == o_level`, the counter clears.
  - Otherwise it increments.
  - When it equals DEBOUNCE_CYC-1 while still mismatched, o_level toggles on the next edge and the counter clears.
  - Any bounce back to the current o_level before that point restarts the count.
- **Event pulses.** o_press/o_release are asserted in the same cycle o_level changes 0→1 / 1→0, using registered edge detect on the next-state value.
- **Repeat FSM** (states in package):
  - S_UP: o_level = 0. On press: go to S_DLY and load the repeat counter.
  - S_DLY: counts REPEAT_DLY cycles. At terminal count: pulse o_rpt, reload with REPEAT_PER, go to S_RPT.
  - S_RPT: pulse o_rpt every REPEAT_PER cycles.
  - From S_DLY or S_RPT, o_level falling returns to S_UP immediately. No o_rpt in the release cycle or after it.
  - If the REPEAT_MASK bit is 0, the FSM stays in S_UP and o_rpt is held at 0.
- **Repeat counter.** Width `$clog2(max(REPEAT_DLY, REPEAT_PER))`. Shared by S_DLY and S_RPT.
- **Reset.** i_srst clears all outputs, counters and FSMs to 0/S_UP, and sets synchronizer flops to 1. A key held through reset is treated as a new press: o_press fires after the normal debounce latency once reset is released.
- **Simultaneous events.** Different keys produce pulses in the same cycle independently. No priority or masking between keys.

## Timing
- Reset values: o_level, o_press, o_release and o_rpt are all 0.
- Press latency: raw level stable from clock edge k gives o_press high in cycle k+2+DEBOUNCE_CYC.
- Release latency: identical to press latency.
- Minimum accepted pulse width: DEBOUNCE_CYC stable cycles after synchronization. Shorter glitches produce no event.
- First o_rpt: exactly REPEAT_DLY cycles after o_press. Subsequent o_rpt: every REPEAT_PER cycles.
- All pulses are exactly 1 cycle wide.
- o_press and o_rpt are never asserted in the same cycle for the same key.
- All outputs are registered. No combinational path from i_key.

## Structure
- Package key_cond_pkg holds:
  - the repeat FSM state typedef (S_UP, S_DLY, S_RPT, 2-bit encoding);
  - default timing constants (DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER at 50 MHz).
- Sub-module key_cond_chan is the single-key channel: synchronizer, debounce counter, edge detect and repeat FSM. It has a REPEAT_EN parameter.
- key_cond is a generate loop of NUM_KEYS key_cond_chan instances.

## Test plan
Bench parameters: DEBOUNCE_CYC=8, REPEAT_DLY=20, REPEAT_PER=5, REPEAT_MASK=4'b0100.

1. **Clean press.** Drive i_key[0]=0 from edge 10 and hold. Required: o_press[0] high only in cycle 20, o_level[0]=1 from cycle 20, o_rpt[0] never asserted. Releasing at edge 40 gives o_release[0] in cycle 50.
2. **Bounce.** Toggle i_key[1] every 3 cycles for 30 cycles, then hold low. Required: no events during toggling; exactly one o_press[1], 10 cycles after the last transition.
3. **Auto-repeat.** Hold i_key[2] low. Required: o_press at cycle P, then o_rpt at P+20, P+25, P+30 and so on. Release mid-period: o_release fires and no further o_rpt.
4. **Reset mid-hold.** Assert i_srst for 3 cycles while key 2 is in S_RPT and still held. Required: all outputs 0 during reset; o_press[2] fires 10 cycles after i_srst deasserts; the repeat sequence restarts from REPEAT_DLY.
5. **Simultaneous.** Press keys 0 and 3 on the same edge. Required: o_press=4'b1001 in a single cycle, and no o_rpt on either key.
6. **Sub-threshold glitch.** Drive a 7-cycle low pulse on i_key[3]. Required: no o_press, and o_level[3] stays 0.
